filter_seq_ctrl: RTL and testbench

FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

---
 rtl/filter_pkg.sv | 35 +++
 rtl/filter_seq_ctrl_if.sv | 19 +
 rtl/mod_counter.sv | 35 +++
 rtl/filter_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_filter_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared state type, address-mux encodings and default sizing for the filter sequencer.
package filter_pkg;

  localparam int FILT_LEN_DEF  = 16;
  localparam int BUF_DEPTH_DEF = 16;
  localparam int PACK_DEF      = 4;
  localparam int OUT_CNT_DEF   = 44;
  localparam int STRIDE_W_DEF  = 2;

  localparam logic [1:0] ADDR_IN   = 2'b00;
  localparam logic [1:0] ADDR_FILT = 2'b01;
  localparam logic [1:0] ADDR_OUT  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_INIT,
    ST_LOAD_FILT,
    ST_FILL_BUF,
    ST_WIN_LD,
    ST_MAC,
    ST_SHIFT,
    ST_DECIDE,
    ST_MEM_WR,
    ST_REFILL,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Counter width for a given modulus; a modulus of 1 still needs one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/filter_seq_ctrl_if.sv
// Memory-side handshake of the filter sequencer: address mux, pointer control and strobes.
interface filter_seq_ctrl_if;
  logic       mem_ready;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] addr_sel;
  logic       ptr_init;
  logic [2:0] ptr_inc;

  modport master (
    input  mem_ready,
    output mem_rd, mem_wr, addr_sel, ptr_init, ptr_inc
  );

  modport slave (
    output mem_ready,
    input  mem_rd, mem_wr, addr_sel, ptr_init, ptr_inc
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear (priority over enable) and terminal-count flag.
module mod_counter
  import filter_pkg::*;
#(
  parameter  int MOD = 4,
  localparam int W   = cnt_width(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MOD - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/filter_seq_ctrl.sv
// Sequencer for a FIR datapath: loads taps, fills the sample window, runs MAC bursts
// and packs results into memory words, with stall, abort and partial-word flush.
module filter_seq_ctrl
  import filter_pkg::*;
#(
  parameter  int FILT_LEN  = FILT_LEN_DEF,
  parameter  int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter  int PACK      = PACK_DEF,
  parameter  int OUT_CNT   = OUT_CNT_DEF,
  parameter  int STRIDE_W  = STRIDE_W_DEF,
  localparam int TAP_W     = cnt_width(FILT_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [STRIDE_W-1:0] stride_i,
  input  logic                abort_i,
  filter_seq_ctrl_if.master   mem_if,
  output logic                filt_we_o,
  output logic                buf_we_o,
  output logic                buf_shift_o,
  output logic                win_ld_o,
  output logic                mac_en_o,
  output logic                mac_clr_o,
  output logic                res_shift_o,
  output logic [TAP_W-1:0]    tap_idx_o,
  output logic                finalize_o,
  output logic                busy_o,
  output logic                done_o
);
  // state      | meaning
  // IDLE       | waiting for start, done=1
  // ARM        | start high, run begins when it falls (stride latched)
  // INIT       | reload address pointers
  // LOAD_FILT  | read FILT_LEN taps
  // FILL_BUF   | read BUF_DEPTH samples into the window buffer
  // WIN_LD     | load MAC window
  // MAC        | FILT_LEN multiply-accumulate steps
  // SHIFT      | shift result into pack register
  // DECIDE     | clear MAC, choose write / flush / refill
  // MEM_WR     | write full packed word
  // REFILL     | read stride+1 new samples
  // FLUSH      | write padded partial word if any
  // DONE       | one-cycle completion

  localparam int BUF_W  = cnt_width(BUF_DEPTH);
  localparam int PACK_W = cnt_width(PACK + 1);
  localparam int OUT_W  = cnt_width(OUT_CNT + 1);

  state_t              state_q, state_d;
  logic [STRIDE_W-1:0] stride_q, stride_d;

  logic busy, abort_act, run_clr, shift_en;
  logic tap_en, tap_tc, fill_en, fill_tc, refill_en, refill_last;
  logic pack_tc, out_tc;
  logic [TAP_W-1:0]    tap_cnt;
  logic [PACK_W-1:0]   pack_cnt;
  logic [STRIDE_W-1:0] refill_cnt;
  logic [BUF_W-1:0]    unused_buf_cnt;
  logic [OUT_W-1:0]    unused_out_cnt;
  logic                unused_refill_tc;

  logic       mem_rd, mem_wr, ptr_init;
  logic [1:0] addr_sel;
  logic [2:0] ptr_inc;

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign abort_act   = abort_i && busy;
  assign run_clr     = (state_q == ST_INIT) || abort_act;
  assign shift_en    = (state_q == ST_SHIFT);
  assign tap_en      = ((state_q == ST_LOAD_FILT) && mem_if.mem_ready) || (state_q == ST_MAC);
  assign fill_en     = (state_q == ST_FILL_BUF) && mem_if.mem_ready;
  assign refill_en   = (state_q == ST_REFILL) && mem_if.mem_ready;
  assign refill_last = refill_en && (refill_cnt == stride_q);

  mod_counter #(.MOD(FILT_LEN)) u_tap_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(tap_en), .clr_i(run_clr),
    .cnt_o(tap_cnt), .tc_o(tap_tc)
  );

  mod_counter #(.MOD(BUF_DEPTH)) u_buf_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(fill_en), .clr_i(run_clr),
    .cnt_o(unused_buf_cnt), .tc_o(fill_tc)
  );

  // Counts to PACK (one past a modulo-PACK count) so DECIDE can see a full word.
  mod_counter #(.MOD(PACK + 1)) u_pack_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(shift_en),
    .clr_i(run_clr || ((state_q == ST_DECIDE) && pack_tc)),
    .cnt_o(pack_cnt), .tc_o(pack_tc)
  );

  mod_counter #(.MOD(OUT_CNT + 1)) u_out_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(shift_en), .clr_i(run_clr),
    .cnt_o(unused_out_cnt), .tc_o(out_tc)
  );

  mod_counter #(.MOD(2 ** STRIDE_W)) u_refill_cnt (
    .clk(clk), .rst_n(rst_n), .en_i(refill_en), .clr_i(run_clr || refill_last),
    .cnt_o(refill_cnt), .tc_o(unused_refill_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    addr_sel    = ADDR_IN;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ptr_init    = 1'b0;
    ptr_inc     = 3'b000;
    filt_we_o   = 1'b0;
    buf_we_o    = 1'b0;
    buf_shift_o = 1'b0;
    win_ld_o    = 1'b0;
    mac_en_o    = 1'b0;
    mac_clr_o   = 1'b0;
    res_shift_o = 1'b0;
    finalize_o  = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        done_o = 1'b1;
        if (start_i) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!start_i) begin
          state_d  = ST_INIT;
          stride_d = stride_i;
        end
      end
      ST_INIT: begin
        ptr_init = 1'b1;
        state_d  = ST_LOAD_FILT;
      end
      ST_LOAD_FILT: begin
        addr_sel = ADDR_FILT;
        mem_rd   = 1'b1;
        if (mem_if.mem_ready) begin
          filt_we_o = 1'b1;
          ptr_inc   = 3'b010;
          if (tap_tc) state_d = ST_FILL_BUF;
        end
      end
      ST_FILL_BUF, ST_REFILL: begin
        mem_rd = 1'b1;
        if (mem_if.mem_ready) begin
          buf_we_o    = 1'b1;
          buf_shift_o = 1'b1;
          ptr_inc     = 3'b001;
          if ((state_q == ST_FILL_BUF) ? fill_tc : refill_last) state_d = ST_WIN_LD;
        end
      end
      ST_WIN_LD: begin
        win_ld_o = 1'b1;
        state_d  = ST_MAC;
      end
      ST_MAC: begin
        mac_en_o = 1'b1;
        if (tap_tc) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        res_shift_o = 1'b1;
        state_d     = ST_DECIDE;
      end
      ST_DECIDE: begin
        mac_clr_o = 1'b1;
        if (pack_tc)     state_d = ST_MEM_WR;
        else if (out_tc) state_d = ST_FLUSH;
        else             state_d = ST_REFILL;
      end
      ST_MEM_WR: begin
        addr_sel = ADDR_OUT;
        mem_wr   = 1'b1;
        if (mem_if.mem_ready) begin
          ptr_inc = 3'b100;
          state_d = out_tc ? ST_FLUSH : ST_REFILL;
        end
      end
      ST_FLUSH: begin
        if (pack_cnt == '0) begin
          state_d = ST_DONE;
        end else begin
          addr_sel   = ADDR_OUT;
          mem_wr     = 1'b1;
          finalize_o = 1'b1;
          if (mem_if.mem_ready) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a ready memory, and suppresses all strobes.
    if (abort_act) begin
      state_d     = ST_IDLE;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      ptr_init    = 1'b0;
      ptr_inc     = 3'b000;
      filt_we_o   = 1'b0;
      buf_we_o    = 1'b0;
      buf_shift_o = 1'b0;
      win_ld_o    = 1'b0;
      mac_en_o    = 1'b0;
      mac_clr_o   = 1'b0;
      res_shift_o = 1'b0;
      finalize_o  = 1'b0;
    end
  end

  assign mem_if.mem_rd   = mem_rd;
  assign mem_if.mem_wr   = mem_wr;
  assign mem_if.addr_sel = addr_sel;
  assign mem_if.ptr_init = ptr_init;
  assign mem_if.ptr_inc  = ptr_inc;
  assign tap_idx_o       = tap_cnt;
  assign busy_o          = busy;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Bench for filter_seq_ctrl: a default instance and a short-run instance (OUT_CNT=10),
// memory writes scored against an expected-write queue.
module tb_filter_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, abort;
  logic [1:0] stride;
  logic       filt_we, buf_we, buf_shift, win_ld, mac_en, mac_clr, res_shift, finalize, busy, done;
  logic [3:0] tap_idx;

  logic       start_b, abort_b;
  logic [1:0] stride_b;
  logic       filt_we_b, buf_we_b, buf_shift_b, win_ld_b, mac_en_b, mac_clr_b, res_shift_b;
  logic       finalize_b, busy_b, done_b;
  logic [3:0] tap_idx_b;

  filter_seq_ctrl_if bus_a();
  filter_seq_ctrl_if bus_b();

  filter_seq_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stride_i(stride), .abort_i(abort),
    .mem_if(bus_a), .filt_we_o(filt_we), .buf_we_o(buf_we), .buf_shift_o(buf_shift),
    .win_ld_o(win_ld), .mac_en_o(mac_en), .mac_clr_o(mac_clr), .res_shift_o(res_shift),
    .tap_idx_o(tap_idx), .finalize_o(finalize), .busy_o(busy), .done_o(done)
  );

  filter_seq_ctrl #(.OUT_CNT(10), .PACK(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .stride_i(stride_b), .abort_i(abort_b),
    .mem_if(bus_b), .filt_we_o(filt_we_b), .buf_we_o(buf_we_b), .buf_shift_o(buf_shift_b),
    .win_ld_o(win_ld_b), .mac_en_o(mac_en_b), .mac_clr_o(mac_clr_b), .res_shift_o(res_shift_b),
    .tap_idx_o(tap_idx_b), .finalize_o(finalize_b), .busy_o(busy_b), .done_o(done_b)
  );

  int checks = 0;
  int failures = 0;
  int n_filt_rd, n_in_inc, n_out_inc, n_win_ld, n_mac_en, n_mac_clr, n_strobe, n_wr, n_wr_b;
  bit exp_q[$];
  bit obs_q[$];
  bit exp_b_q[$];
  bit obs_b_q[$];

  task automatic clear_counts();
    n_filt_rd = 0; n_in_inc = 0; n_out_inc = 0; n_win_ld = 0; n_mac_en = 0;
    n_mac_clr = 0; n_strobe = 0; n_wr = 0; n_wr_b = 0;
    exp_q.delete(); obs_q.delete(); exp_b_q.delete(); obs_b_q.delete();
  endtask

  // Samples the cycle's outputs just before the edge, records observed writes, then advances.
  task automatic tick();
    #1;
    if (bus_a.mem_rd && bus_a.mem_ready && bus_a.addr_sel == 2'b01) n_filt_rd++;
    if (bus_a.ptr_inc[0]) n_in_inc++;
    if (bus_a.ptr_inc[2]) n_out_inc++;
    if (win_ld) n_win_ld++;
    if (mac_en) n_mac_en++;
    if (mac_clr) n_mac_clr++;
    if (bus_a.mem_rd || bus_a.mem_wr) n_strobe++;
    if (bus_a.mem_wr && bus_a.mem_ready) begin n_wr++; obs_q.push_back(finalize); end
    if (bus_b.mem_wr && bus_b.mem_ready) begin n_wr_b++; obs_b_q.push_back(finalize_b); end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int budget, output bit ok);
    bit seen_busy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy) seen_busy = 1'b1;
      if (seen_busy && done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stride = 2'd0; bus_a.mem_ready = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; stride_b = 2'd0; bus_b.mem_ready = 1'b1;
    #7;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({bus_a.mem_rd, bus_a.mem_wr, bus_a.ptr_init, bus_a.ptr_inc, filt_we, buf_we, buf_shift,
         win_ld, mac_en, mac_clr, res_shift, finalize} !== 14'h0) begin
      failures++; $display("FAIL reset_strobes got=nonzero exp=0");
    end
    checks++; if (bus_a.addr_sel !== 2'b00) begin failures++; $display("FAIL reset_addr_sel got=%b exp=00", bus_a.addr_sel); end
    checks++; if (tap_idx !== 4'd0) begin failures++; $display("FAIL reset_tap_idx got=%0d exp=0", tap_idx); end
    checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL reset_done_b got=%b exp=1", done_b); end
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_a.mem_rd !== 1'b0) begin
      failures++; $display("FAIL idle_after_release got=done%b/busy%b exp=done1/busy0", done, busy);
    end
  endtask

  task automatic test_full_run();
    bit ok, e, o;
    int idx = 0;
    clear_counts();
    stride = 2'd0; bus_a.mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    run_to_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
    checks++; if (n_filt_rd != 16) begin failures++; $display("FAIL full_filt_reads got=%0d exp=16", n_filt_rd); end
    checks++; if (n_in_inc != 59) begin failures++; $display("FAIL full_in_inc got=%0d exp=59", n_in_inc); end
    checks++; if (n_win_ld != 44) begin failures++; $display("FAIL full_bursts got=%0d exp=44", n_win_ld); end
    checks++; if (n_mac_en != 704) begin failures++; $display("FAIL full_mac_en got=%0d exp=704", n_mac_en); end
    checks++; if (n_mac_clr != 44) begin failures++; $display("FAIL full_mac_clr got=%0d exp=44", n_mac_clr); end
    checks++; if (n_out_inc != 11) begin failures++; $display("FAIL full_out_inc got=%0d exp=11", n_out_inc); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL full_wr_finalize[%0d] got=%b exp=%b", idx, o, e); end
      idx++;
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL full_wr_count got=%0d exp=11", n_wr);
    end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full_idle_after got=done%b exp=done1", done); end
  endtask

  task automatic test_stride();
    bit ok;
    clear_counts();
    stride = 2'd2; bus_a.mem_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0; tick();
    stride = 2'd0;
    repeat (40) tick();
    start = 1'b1; tick(); start = 1'b0;
    run_to_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stride_timeout got=no_done exp=done"); end
    checks++; if (n_in_inc != 145) begin failures++; $display("FAIL stride_in_inc got=%0d exp=145", n_in_inc); end
    checks++; if (n_wr != 11) begin failures++; $display("FAIL stride_wr got=%0d exp=11", n_wr); end
    checks++; if (n_win_ld != 44) begin failures++; $display("FAIL stride_bursts got=%0d exp=44", n_win_ld); end
    tick();
  endtask

  task automatic test_stall();
    bit ok = 1'b0, seen = 1'b0, stalled = 1'b0, in_ep = 1'b0;
    int stall_left = 0, ep_len = 0, ep_inc = 0, stall_bad = 0;
    clear_counts();
    stride = 2'd0; bus_a.mem_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) seen = 1'b1;
      if (seen && done) begin ok = 1'b1; break; end
      if (!stalled && bus_a.mem_wr) begin stalled = 1'b1; stall_left = 5; in_ep = 1'b1; end
      bus_a.mem_ready = (stall_left == 0);
      #1;
      if (in_ep) begin
        if (bus_a.mem_wr) begin
          ep_len++;
          if (bus_a.ptr_inc[2]) ep_inc++;
        end else begin
          in_ep = 1'b0;
        end
      end
      if (stall_left > 0 && (bus_a.ptr_inc != 3'b000 || res_shift || mac_clr || win_ld)) stall_bad++;
      tick();
      if (stall_left > 0) stall_left--;
    end
    bus_a.mem_ready = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++; if (ep_len != 6) begin failures++; $display("FAIL stall_wr_len got=%0d exp=6", ep_len); end
    checks++; if (ep_inc != 1) begin failures++; $display("FAIL stall_out_inc got=%0d exp=1", ep_inc); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_strobes got=%0d exp=0", stall_bad); end
    checks++; if (n_wr != 11 || n_win_ld != 44) begin failures++; $display("FAIL stall_totals got=wr%0d/out%0d exp=wr11/out44", n_wr, n_win_ld); end
    tick();
  endtask

  task automatic test_abort();
    bit ok, e, o;
    int idx = 0;
    clear_counts();
    stride = 2'd0; bus_a.mem_ready = 1'b1;
    exp_q.push_back(1'b0);  // outputs 1..4 fill one word before the cancel
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (n_win_ld >= 7) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL abort_reach_out7 got=%0d exp=7", n_win_ld); end
    repeat (5) tick();
    checks++; if (tap_idx !== 4'd5 || mac_en !== 1'b1) begin failures++; $display("FAIL abort_mac_tap got=%0d exp=5", tap_idx); end
    abort = 1'b1;
    #1;
    checks++;
    if (bus_a.mem_rd || bus_a.mem_wr || bus_a.ptr_inc != 3'b000) begin
      failures++; $display("FAIL abort_cycle_strobe got=1 exp=0");
    end
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=done%b/busy%b exp=done1/busy0", done, busy); end
    checks++; if (tap_idx !== 4'd0) begin failures++; $display("FAIL abort_tap_clr got=%0d exp=0", tap_idx); end
    n_strobe = 0;
    repeat (20) tick();
    checks++; if (n_strobe != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", n_strobe); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL abort_wr_finalize[%0d] got=%b exp=%b", idx, o, e); end
      idx++;
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL abort_wr_count got=%0d exp=1", n_wr); end

    clear_counts();
    for (int i = 0; i < 11; i++) exp_q.push_back(1'b0);
    start = 1'b1; tick(); start = 1'b0;
    run_to_done(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rerun_timeout got=no_done exp=done"); end
    checks++; if (n_win_ld != 44) begin failures++; $display("FAIL rerun_bursts got=%0d exp=44", n_win_ld); end
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL rerun_wr_finalize[%0d] got=%b exp=%b", idx, o, e); end
      idx++;
    end
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin failures++; $display("FAIL rerun_wr_count got=%0d exp=11", n_wr); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    int bad = 0;
    clear_counts();
    stride = 2'd0; bus_a.mem_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (n_win_ld >= 1 && busy && bus_a.mem_rd && bus_a.addr_sel == 2'b00) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach_refill got=0 exp=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async got=done%b/busy%b exp=done1/busy0", done, busy); end
    checks++;
    if ({bus_a.mem_rd, bus_a.mem_wr, bus_a.ptr_inc, buf_we, buf_shift, tap_idx} !== 13'h0) begin
      failures++; $display("FAIL rstmid_outputs got=nonzero exp=0");
    end
    start = 1'b1;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!busy || bus_a.ptr_init || bus_a.mem_rd) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_arm_hold got=%0d exp=0", bad); end
    start = 1'b0;
    tick();
    checks++; if (bus_a.ptr_init !== 1'b1) begin failures++; $display("FAIL rstmid_init got=%b exp=1", bus_a.ptr_init); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rstmid_abort_idle got=%b exp=1", done); end
  endtask

  task automatic test_out10();
    bit ok = 1'b0, seen = 1'b0, e, o;
    int idx = 0;
    clear_counts();
    exp_b_q.push_back(1'b0); exp_b_q.push_back(1'b0); exp_b_q.push_back(1'b1);
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (busy_b) seen = 1'b1;
      if (seen && done_b) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL out10_timeout got=no_done exp=done"); end
    checks++; if (n_wr_b != 3) begin failures++; $display("FAIL out10_wr got=%0d exp=3", n_wr_b); end
    while (exp_b_q.size() > 0 && obs_b_q.size() > 0) begin
      e = exp_b_q.pop_front(); o = obs_b_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL out10_wr_finalize[%0d] got=%b exp=%b", idx, o, e); end
      idx++;
    end
    checks++;
    if (exp_b_q.size() != 0 || obs_b_q.size() != 0) begin failures++; $display("FAIL out10_wr_count got=%0d exp=3", n_wr_b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stride();
    test_stall();
    test_abort();
    test_reset_mid();
    test_out10();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
